seg7_scan_reader: RTL and testbench

Receiving end of the multiplexed 7-segment display interface. The block samples the active-high segment bus and one-hot digit-enable strobes that our hex-to-segment drivers produce, and waits for each digit's pattern to be stable. It then decodes the pattern back to a hex nibble and assembles a full frame once every digit has been captured. It sits beside the display driver for loop-back self-test, or on a board input watching an external display bus.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_pattern_decode.sv | 25 ++
 rtl/seg7_scan_reader.sv | 118 +++++++++++
 tb/tb_seg7_scan_reader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns shared with the hex-to-segment driver
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'h3F;
   localparam seg_t SEG_1     = 7'h06;
   localparam seg_t SEG_2     = 7'h5B;
   localparam seg_t SEG_3     = 7'h4F;
   localparam seg_t SEG_4     = 7'h66;
   localparam seg_t SEG_5     = 7'h6D;
   localparam seg_t SEG_6     = 7'h7D;
   localparam seg_t SEG_7     = 7'h07;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h6F;
   localparam seg_t SEG_A     = 7'h77;
   localparam seg_t SEG_B     = 7'h7C;
   localparam seg_t SEG_C     = 7'h39;
   localparam seg_t SEG_D     = 7'h5E;
   localparam seg_t SEG_E     = 7'h79;
   localparam seg_t SEG_F     = 7'h71;
   localparam seg_t SEG_BLANK = 7'h00;

   localparam seg_t SEG_TABLE [16] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
      SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
   };

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: segment pattern back to hex nibble, flagging blank and non-hex patterns
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       invalid
);

   assign blank = seg == SEG_BLANK;

   // Search the driver table; any unmatched, non-blank pattern is an error
   always_comb begin
      nibble  = 4'd0;
      invalid = seg != SEG_BLANK;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            nibble  = 4'(i);
            invalid = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: captures stable digits of a multiplexed 7-segment bus and assembles hex frames
module seg7_scan_reader
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   dig_en,
   output logic [4*NUM_DIGITS-1:0] value_out,
   output logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic                    frame_valid,
   output logic                    glitch
);

   localparam logic [0:0] WAIT   = 1'b0;
   localparam logic [0:0] HELD   = 1'b1;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   seg_t                    samp_seg;
   logic [NUM_DIGITS-1:0]   samp_en;
   logic [7:0]              cnt;
   logic [0:0]              state [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   seen;
   logic [NUM_DIGITS-1:0]   cap;
   logic [4*NUM_DIGITS-1:0] sh_val, sh_val_n;
   logic [NUM_DIGITS-1:0]   sh_blank, sh_blank_n;
   logic [NUM_DIGITS-1:0]   sh_err, sh_err_n;
   logic [3:0]              nibble;
   logic                    blank;
   logic                    invalid;
   logic                    in_onehot;
   logic                    stable;
   logic                    done;

   assign in_onehot = $onehot(dig_en);
   assign stable    = cnt == STABLE;
   assign done      = &seen;

   seg7_pattern_decode u_decode (
      .seg     (samp_seg),
      .nibble  (nibble),
      .blank   (blank),
      .invalid (invalid)
   );

   // Register the bus and count how long it has held one identical one-hot sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_seg <= '0;
         samp_en  <= '0;
         cnt      <= '0;
         glitch   <= 1'b0;
      end else begin
         samp_seg <= seg;
         samp_en  <= dig_en;
         cnt      <= !in_onehot ? 8'd0 :
                     ({seg, dig_en} != {samp_seg, samp_en}) ? 8'd1 :
                     stable ? cnt : cnt + 8'd1;
         glitch   <= $countones(dig_en) > 1;
      end
   end

   // Capture strobes and the shadow slots as they look after this edge's capture
   always_comb begin
      cap        = '0;
      sh_val_n   = sh_val;
      sh_blank_n = sh_blank;
      sh_err_n   = sh_err;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         cap[i] = stable && samp_en[i] && state[i] == WAIT;
         if (cap[i]) begin
            sh_val_n[4*i +: 4] = nibble;
            sh_blank_n[i]      = blank;
            sh_err_n[i]        = invalid;
         end
      end
   end

   // One capture per stable dwell; any restart of stability re-arms every digit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) state[i] <= WAIT;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) state[i] <= !stable ? WAIT : cap[i] ? HELD : state[i];
      end
   end

   // Shadow slots, seen mask and frame hand-off; a capture on the completing edge joins that frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_val      <= '0;
         sh_blank    <= '0;
         sh_err      <= '0;
         seen        <= '0;
         value_out   <= '0;
         blank_mask  <= '0;
         err_mask    <= '0;
         frame_valid <= 1'b0;
      end else begin
         sh_val      <= sh_val_n;
         sh_blank    <= sh_blank_n;
         sh_err      <= sh_err_n;
         seen        <= done ? '0 : seen | cap;
         frame_valid <= done;
         if (done) begin
            value_out  <= sh_val_n;
            blank_mask <= sh_blank_n;
            err_mask   <= sh_err_n;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: randomized and directed scans checked against a history-based reference model
module tb_seg7_scan_reader;

   localparam int N = 4;
   localparam int S = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [6:0]     seg = '0;
   logic [N-1:0]   dig_en = '0;
   logic [4*N-1:0] value_out;
   logic [N-1:0]   blank_mask, err_mask;
   logic           frame_valid, glitch;

   int n_cmp = 0;
   int n_bad = 0;
   int frames = 0;
   logic [15:0] last_val = '0;
   logic [3:0]  last_blank = '0, last_err = '0;

   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [15:0] e_val = '0;
   logic [3:0]  e_blank = '0, e_err = '0;
   logic        e_fv = 1'b0, e_gl = 1'b0;
   logic [15:0] m_val = '0;
   logic [3:0]  m_blank = '0, m_err = '0, m_seen = '0;
   logic [10:0] hist [$];

   seg7_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .dig_en      (dig_en),
      .value_out   (value_out),
      .blank_mask  (blank_mask),
      .err_mask    (err_mask),
      .frame_valid (frame_valid),
      .glitch      (glitch)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ref_decode(input logic [6:0] p);
      if (p == 7'h00) return 6'b000010;
      for (int i = 0; i < 16; i++) if (tbl[i] == p) return {i[3:0], 2'b00};
      return 6'b000001;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic show(input int d, input logic [6:0] p, input int n);
      repeat (n) begin
         @(negedge clk);
         seg = p;
         dig_en = 4'(1 << d);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         seg = '0;
         dig_en = '0;
      end
   endtask

   // Reference model: a digit is captured on the edge after exactly S identical one-hot samples in a row
   initial begin : model
      int n, d;
      bit run;
      logic [10:0] last;
      logic [5:0] dec;
      logic [3:0] cap;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            hist.delete();
            m_val = '0; m_blank = '0; m_err = '0; m_seen = '0;
            e_val = '0; e_blank = '0; e_err = '0; e_fv = 1'b0; e_gl = 1'b0;
         end else begin
            n = hist.size();
            cap = '0;
            run = 1'b0;
            if (n >= S) begin
               last = hist[n-1];
               run = $onehot(last[3:0]) && (n == S || hist[n-S-1] != last);
               for (int i = 2; i <= S; i++) if (hist[n-i] != last) run = 1'b0;
               if (run) begin
                  d = 0;
                  for (int i = 0; i < N; i++) if (last[i]) d = i;
                  dec = ref_decode(last[10:4]);
                  m_val[4*d +: 4] = dec[5:2];
                  m_blank[d] = dec[1];
                  m_err[d] = dec[0];
                  cap[d] = 1'b1;
               end
            end
            e_fv = m_seen == 4'hF;
            if (e_fv) begin
               e_val = m_val; e_blank = m_blank; e_err = m_err;
               m_seen = '0;
            end else begin
               m_seen = m_seen | cap;
            end
            e_gl = $countones(dig_en) > 1;
            hist.push_back({seg, dig_en});
            if (hist.size() > S + 1) void'(hist.pop_front());
         end
      end
   end

   // Compare every output against the model each cycle, away from the active edge
   initial begin : compare
      forever begin
         @(negedge clk);
         check("value_out", 32'(value_out), 32'(e_val));
         check("blank_mask", 32'(blank_mask), 32'(e_blank));
         check("err_mask", 32'(err_mask), 32'(e_err));
         check("frame_valid", 32'(frame_valid), 32'(e_fv));
         check("glitch", 32'(glitch), 32'(e_gl));
         if (frame_valid) begin
            frames++;
            last_val = value_out; last_blank = blank_mask; last_err = err_mask;
         end
      end
   end

   initial begin : stim
      int f0, d, r, dw;
      logic [6:0] p;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      f0 = frames;
      show(0, 7'h3F, 6); gap(1); show(1, 7'h06, 6); gap(1);
      show(2, 7'h5B, 6); gap(1); show(3, 7'h4F, 6); gap(2);
      check("t1_frames", 32'(frames), 32'(f0 + 1));
      check("t1_value", 32'(last_val), 32'h3210);
      check("t1_model", 32'(e_val), 32'h3210);
      check("t1_masks", 32'({last_blank, last_err}), 32'h0);

      f0 = frames;
      show(0, 7'h66, 6); gap(1); show(1, 7'h6D, 6); gap(1);
      show(2, 7'h7D, 3); gap(1); show(3, 7'h07, 6); gap(3);
      check("t2_no_frame", 32'(frames), 32'(f0));
      show(2, 7'h7D, 6); gap(2);
      check("t2_frame", 32'(frames), 32'(f0 + 1));
      check("t2_value", 32'(last_val), 32'h7654);

      show(0, 7'h7F, 6); gap(1); show(1, 7'h00, 6); gap(1);
      show(2, 7'h6F, 6); gap(1); show(3, 7'h7E, 6); gap(2);
      check("t3_value", 32'(last_val), 32'h0908);
      check("t3_blank", 32'(last_blank), 32'b0010);
      check("t3_err", 32'(last_err), 32'b1000);

      f0 = frames;
      show(0, 7'h3F, 2);
      @(negedge clk); dig_en = 4'b0110;
      @(negedge clk);
      check("t4_glitch", 32'(glitch), 32'h1);
      dig_en = 4'b0001;
      show(0, 7'h3F, 3); gap(1);
      show(1, 7'h5B, 6); gap(1); show(2, 7'h4F, 6); gap(1); show(3, 7'h66, 6); gap(2);
      check("t4_frame", 32'(frames), 32'(f0 + 1));
      check("t4_value", 32'(last_val), 32'h4320);

      show(0, 7'h71, 6); gap(1); show(0, 7'h79, 6); gap(1);
      show(1, 7'h06, 6); gap(1); show(2, 7'h06, 6); gap(1); show(3, 7'h06, 6); gap(2);
      check("t5_value", 32'(last_val), 32'h111E);

      show(0, 7'h3F, 6); gap(1); show(1, 7'h06, 6); gap(1);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t6_rst_value", 32'(value_out), 32'h0);
         check("t6_rst_masks", 32'({blank_mask, err_mask}), 32'h0);
         check("t6_rst_pulses", 32'({frame_valid, glitch}), 32'h0);
      end
      rst = 1'b0;
      f0 = frames;
      show(0, 7'h71, 6); gap(1); show(1, 7'h7C, 6); gap(1);
      show(2, 7'h39, 6); gap(1); show(3, 7'h5E, 6); gap(2);
      check("t6_frames", 32'(frames), 32'(f0 + 1));
      check("t6_value", 32'(last_val), 32'hDCBF);
      check("t6_masks", 32'({last_blank, last_err}), 32'h0);

      for (int k = 0; k < 300; k++) begin
         d  = $urandom_range(0, N - 1);
         r  = $urandom_range(0, 9);
         dw = $urandom_range(1, 8);
         p  = r < 7 ? tbl[$urandom_range(0, 15)] : r < 8 ? 7'h00 : 7'($urandom);
         show(d, p, dw);
         if ($urandom_range(0, 5) == 0) begin
            @(negedge clk);
            dig_en = 4'($urandom);
         end
         gap($urandom_range(0, 2));
      end
      gap(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
